regfile_rv_sb: RTL
==================

# regfile_rv_sb

Parametrised successor to the RV32I register file: a configurable-width, configurable-depth integer register file with two read ports, one write port, write-to-read bypass, an optional registered-read mode, and a per-register pending-write scoreboard. It sits between decode (read and reserve) and writeback (write and release) in the pipelined core. The scoreboard lets decode stall on load-use and other long-latency hazards without external tracking logic.

## Interface
Parameters:
- DATA_W, 32, register data width in bits
- NUM_REGS, 32, number of architectural registers; power of two, at least 2
- ADDR_W, $clog2(NUM_REGS), register address width; derived, never overridden
- READ_REG, 0, read mode: 0 = combinational read, 1 = registered read with 1-cycle latency
- BYPASS, 1, write-to-read forwarding: 1 = enabled, 0 = disabled

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- RegWriteControl  in  1  write enable
- RegWriteAddr  in  ADDR_W  write address
- RegDataIn  in  DATA_W  write data
- RegData1  in  ADDR_W  read address, port 1
- RegData2  in  ADDR_W  read address, port 2
- RegReserve  in  1  marks RegReserveAddr pending
- RegReserveAddr  in  ADDR_W  register to reserve
- RegDataOut1  out  DATA_W  read data, port 1
- RegDataOut2  out  DATA_W  read data, port 2
- RegReady1  out  1  port 1 operand is not pending, or is being written this cycle
- RegReady2  out  1  port 2 operand is not pending, or is being written this cycle
- RegBusy  out  NUM_REGS  pending bit vector; bit n is set while register n is reserved

## Operation
- Storage: NUM_REGS x DATA_W registers and a NUM_REGS-bit pending vector.
- Register 0:
  - Always reads 0 and is always ready.
  - Writes to it are ignored.
  - Reservations of it are ignored, so RegBusy[0] is always 0.
- Write: when RegWriteControl = 1 and RegWriteAddr != 0, the register takes RegDataIn at the clock edge. The same edge clears the pending bit of that register.
- Reserve: when RegReserve = 1 and RegReserveAddr != 0, the pending bit is set at the clock edge.
- Reserve and write to the same address in the same cycle: reserve wins and the bit ends set. This is a new producer issuing while the old one retires; the data is still written.
- Read with READ_REG=0: RegDataOutN = mem[RegDataN].
  - If BYPASS=1, RegWriteControl=1 and RegWriteAddr==RegDataN!=0, the output is RegDataIn instead.
- Read with READ_REG=1: RegDataOutN is registered and shows, one edge later, the value the combinational path would show. Bypass is applied before the output register, so a read and a write to the same address in one cycle return the new data.
- Ready: RegReadyN = !pending[RegDataN].
  - If BYPASS=1 and a write to RegDataN (non-zero) is active, RegReadyN = 1.
  - With READ_REG=1, ready is registered alongside the data.
- Both read ports operate independently and may use the same address.
- No arithmetic is performed; address compares are ADDR_W-bit equality.

## Timing
- Reset, asynchronous, takes effect immediately: all registers = 0, pending = 0, RegBusy = 0. In READ_REG=1, RegDataOut1/2 = 0 and RegReady1/2 = 1.
- In READ_REG=0 during reset, outputs follow the cleared state: data 0, ready 1.
- Reset deasserted mid-operation: the first edge after release behaves normally. Writes or reserves asserted during reset are lost.
- Write latency: data is visible through the array on the cycle after the edge, or the same cycle via bypass.
- Read latency: 0 cycles (READ_REG=0) or 1 cycle (READ_REG=1).
- Pending bit changes are visible on RegBusy the cycle after the edge.
- No handshake back-pressure: every write and reserve is accepted unconditionally.

## Test plan
- Reset with defaults → all outputs 0, RegReady1/2 = 1. Write 897 to x1 then 666 to x2; read RegData1=1, RegData2=2 → 897 and 666.
- Write 0xDEADBEEF to x0, then read x0 on both ports → 0, ready 1. Reserve x0 → RegBusy[0] stays 0.
- BYPASS=1, READ_REG=0: write 0x1234 to x5 while RegData1=5 in the same cycle → RegDataOut1 = 0x1234 that cycle. With BYPASS=0 → old value 0 that cycle, 0x1234 next cycle.
- Reserve x7 → RegBusy[7]=1 and RegReady1=0 for RegData1=7. Write 42 to x7 → RegReady1=1 in the write cycle (bypass), RegBusy[7]=0 after the edge.
- Reserve and write x9 in the same cycle → after the edge x9 = written value and RegBusy[9] = 1. Next write clears it.
- READ_REG=1: write 100 to x3, read x3 in the same cycle → RegDataOut1 = 100 one edge later. Assert reset mid-sequence with x3 reserved → RegBusy = 0 and RegDataOut1 = 0 immediately, without a clock edge.

Source files
------------

// File: rtl/regfile_rv_sb.sv
// Parametrised integer register file: two read ports, one write port, optional
// write-to-read bypass, optional registered read, and a per-register pending scoreboard.
module regfile_rv_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    localparam int ADDR_W  = $clog2(NUM_REGS),
    parameter int READ_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                RegWriteControl,
    input  logic [ADDR_W-1:0]   RegWriteAddr,
    input  logic [DATA_W-1:0]   RegDataIn,
    input  logic [ADDR_W-1:0]   RegData1,
    input  logic [ADDR_W-1:0]   RegData2,
    input  logic                RegReserve,
    input  logic [ADDR_W-1:0]   RegReserveAddr,
    output logic [DATA_W-1:0]   RegDataOut1,
    output logic [DATA_W-1:0]   RegDataOut2,
    output logic                RegReady1,
    output logic                RegReady2,
    output logic [NUM_REGS-1:0] RegBusy
);

    // Writes and reserves have no back-pressure: any asserted enable is
    // accepted on the next rising edge; address 0 is silently dropped.
    logic [DATA_W-1:0]   r_mem [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;
    logic [NUM_REGS-1:0] w_pend_next;
    logic                w_we;
    logic                w_rsv;
    logic                w_byp1;
    logic                w_byp2;
    logic [DATA_W-1:0]   w_rd1;
    logic [DATA_W-1:0]   w_rd2;
    logic                w_rdy1;
    logic                w_rdy2;

    assign w_we  = RegWriteControl && (RegWriteAddr != '0);
    assign w_rsv = RegReserve && (RegReserveAddr != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            r_mem[RegWriteAddr] <= RegDataIn;
        end
    end

    // A reserve landing on the register being retired keeps the bit set.
    always_comb begin
        w_pend_next = r_pend;
        if (w_we) begin
            w_pend_next[RegWriteAddr] = 1'b0;
        end
        if (w_rsv) begin
            w_pend_next[RegReserveAddr] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    assign RegBusy = r_pend;

    assign w_byp1 = (BYPASS != 0) && w_we && (RegWriteAddr == RegData1);
    assign w_byp2 = (BYPASS != 0) && w_we && (RegWriteAddr == RegData2);

    always_comb begin
        w_rd1  = r_mem[RegData1];
        w_rdy1 = !r_pend[RegData1];
        if (RegData1 == '0) begin
            w_rd1  = '0;
            w_rdy1 = 1'b1;
        end else if (w_byp1) begin
            w_rd1  = RegDataIn;
            w_rdy1 = 1'b1;
        end
    end

    always_comb begin
        w_rd2  = r_mem[RegData2];
        w_rdy2 = !r_pend[RegData2];
        if (RegData2 == '0) begin
            w_rd2  = '0;
            w_rdy2 = 1'b1;
        end else if (w_byp2) begin
            w_rd2  = RegDataIn;
            w_rdy2 = 1'b1;
        end
    end

    generate
        if (READ_REG != 0) begin : g_reg_read
            logic [DATA_W-1:0] r_out1;
            logic [DATA_W-1:0] r_out2;
            logic              r_rdy1;
            logic              r_rdy2;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_out1 <= '0;
                    r_out2 <= '0;
                    r_rdy1 <= 1'b1;
                    r_rdy2 <= 1'b1;
                end else begin
                    r_out1 <= w_rd1;
                    r_out2 <= w_rd2;
                    r_rdy1 <= w_rdy1;
                    r_rdy2 <= w_rdy2;
                end
            end

            assign RegDataOut1 = r_out1;
            assign RegDataOut2 = r_out2;
            assign RegReady1   = r_rdy1;
            assign RegReady2   = r_rdy2;
        end else begin : g_comb_read
            assign RegDataOut1 = w_rd1;
            assign RegDataOut2 = w_rd2;
            assign RegReady1   = w_rdy1;
            assign RegReady2   = w_rdy2;
        end
    endgenerate

endmodule
